// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and grant helper for the memory arbiter
package mem_arbiter_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} ARB_STATE;
   typedef enum logic {GRANT_CPU, GRANT_DBG} ARB_GRANT;

   localparam int CNT_W = 4;

   // Round-robin on a tie: whichever port was not granted last wins.
   function automatic ARB_GRANT arb_pick(input logic cpu_elig, input logic dbg_elig,
                                         input ARB_GRANT last);
      if (cpu_elig && dbg_elig) begin
         return (last == GRANT_CPU) ? GRANT_DBG : GRANT_CPU;
      end else if (cpu_elig) begin
         return GRANT_CPU;
      end
      return GRANT_DBG;
   endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - loadable down-counter timing the memory latency
module arb_wait_counter
   import mem_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             last
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last = (count_q == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter/sequencer for the unified CPU memory
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   input  logic              dbg_lock,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(MEM_LAT);

   ARB_STATE          state_q, state_d;
   ARB_GRANT          grant_q, grant_d;
   ARB_GRANT          last_grant_q, last_grant_d;
   ARB_GRANT          pick;
   logic              cmd_we_q, cmd_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              cpu_elig;
   logic              cnt_load, cnt_dec, cnt_last;

   arb_wait_counter u_wait (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (LAT_VAL),
      .dec      (cnt_dec),
      .last     (cnt_last)
   );

   assign cpu_elig = cpu_req & ~dbg_lock;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cmd_we_d     = cmd_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      pick         = arb_pick(cpu_elig, dbg_req, last_grant_q);
      case (state_q)
         ARB_IDLE: begin
            if (cpu_elig || dbg_req) begin
               grant_d      = pick;
               last_grant_d = pick;
               // Requester inputs are captured here only; later changes are ignored.
               if (pick == GRANT_CPU) begin
                  cmd_we_d    = cpu_we;
                  mem_addr_d  = cpu_addr;
                  mem_wdata_d = cpu_wdata;
               end else begin
                  cmd_we_d    = dbg_we;
                  mem_addr_d  = dbg_addr;
                  mem_wdata_d = dbg_wdata;
               end
               state_d = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            cnt_load = 1'b1;
            state_d  = ARB_WAIT;
         end
         ARB_WAIT: begin
            cnt_dec = 1'b1;
            if (cnt_last) begin
               if (!cmd_we_q && (grant_q == GRANT_CPU)) cpu_rdata_d = mem_rdata;
               if (!cmd_we_q && (grant_q == GRANT_DBG)) dbg_rdata_d = mem_rdata;
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         grant_q      <= GRANT_CPU;
         last_grant_q <= GRANT_DBG;
         cmd_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cmd_we_q     <= cmd_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   assign mem_en    = (state_q == ARB_ISSUE);
   assign mem_we    = mem_en & cmd_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign cpu_ack   = (state_q == ARB_RESP) && (grant_q == GRANT_CPU);
   assign dbg_ack   = (state_q == ARB_RESP) && (grant_q == GRANT_DBG);
   assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          dbg_req, dbg_we, dbg_ack, dbg_lock;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata, dbg_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_lock(dbg_lock),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Memory seen by the DUT, and the reference model's own copy.
   logic [DW-1:0] env_mem [256];
   logic [DW-1:0] mdl_mem [256];
   bit            env_pend;
   int            env_cnt;
   logic [AW-1:0] env_addr;

   // Transaction-level model: age counts cycles since the grant cycle.
   bit            m_busy, m_port, m_last, m_we;
   int            m_age;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_crd, m_drd;

   bit            c_pend, d_pend, c_we, d_we;
   logic [AW-1:0] c_addr, d_addr;
   logic [DW-1:0] c_wdata, d_wdata;
   int            p_new;
   bit            rand_lock;

   int            en_cyc, cack_cyc, dack_cyc, t0, n, stall_low, ncpu, ndbg;
   logic [AW-1:0] en_addr;
   logic [DW-1:0] en_wdata, saved;
   logic          en_we;
   bit            ack_log[$];
   int            ack_cyc_log[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_age = 0; m_last = 1; m_crd = '0; m_drd = '0;
      env_pend = 0; env_cnt = 0; c_pend = 0; d_pend = 0;
   endtask

   task automatic new_req(input bit port);
      if (!port) begin
         c_pend = 1; c_we = 1'($urandom_range(0, 1)); c_addr = $urandom; c_wdata = $urandom;
      end else begin
         d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
      end
   endtask

   task automatic step();
      bit e_en, e_cack, e_dack, ce, de;
      @(posedge clk); #1;
      cyc++;
      if (p_new > 0) begin
         if (!c_pend && ($urandom_range(0, 99) < p_new)) new_req(0);
         if (!d_pend && ($urandom_range(0, 99) < p_new)) new_req(1);
      end
      if (rand_lock && ($urandom_range(0, 19) == 0)) dbg_lock = ~dbg_lock;
      cpu_req = c_pend; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
      dbg_req = d_pend; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wdata;
      if (env_pend) env_cnt++;
      mem_rdata = (env_pend && env_cnt == LAT) ? env_mem[env_addr[7:0]] : $urandom;
      if (env_pend && env_cnt == LAT) env_pend = 0;
      #1;
      e_en   = m_busy && (m_age == 1);
      e_cack = m_busy && (m_age == LAT + 2) && !m_port;
      e_dack = m_busy && (m_age == LAT + 2) && m_port;
      chk("mem_en", mem_en, e_en);
      if (e_en) begin
         chk("mem_we", mem_we, m_we);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("cpu_ack", cpu_ack, e_cack);
      chk("dbg_ack", dbg_ack, e_dack);
      chk("cpu_rdata", cpu_rdata, m_crd);
      chk("dbg_rdata", dbg_rdata, m_drd);
      chk("cpu_stall", cpu_stall, cpu_req & ~e_cack);
      // Environment reacts to what the DUT actually drives.
      if (mem_en) begin
         en_cyc = cyc; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
         if (mem_we) env_mem[mem_addr[7:0]] = mem_wdata;
         else begin env_pend = 1; env_cnt = 0; env_addr = mem_addr; end
      end
      if (cpu_ack) begin c_pend = 0; cack_cyc = cyc; ack_log.push_back(0); ack_cyc_log.push_back(cyc); end
      if (dbg_ack) begin d_pend = 0; dack_cyc = cyc; ack_log.push_back(1); ack_cyc_log.push_back(cyc); end
      if (m_busy) begin
         if (m_age == 1 && m_we) mdl_mem[m_addr[7:0]] = m_wdata;
         if (m_age == LAT + 1 && !m_we) begin
            if (!m_port) m_crd = mdl_mem[m_addr[7:0]];
            else         m_drd = mdl_mem[m_addr[7:0]];
         end
         if (m_age == LAT + 2) m_busy = 0;
         else m_age++;
      end else begin
         ce = cpu_req && !dbg_lock;
         de = dbg_req;
         if (ce || de) begin
            m_port  = (ce && de) ? ~m_last : de;
            m_last  = m_port;
            m_busy  = 1;
            m_age   = 1;
            m_we    = m_port ? dbg_we : cpu_we;
            m_addr  = m_port ? dbg_addr : cpu_addr;
            m_wdata = m_port ? dbg_wdata : cpu_wdata;
         end
      end
   endtask

   task automatic quiesce();
      int k;
      p_new = 0; rand_lock = 0; dbg_lock = 0;
      k = 0;
      while ((m_busy || c_pend || d_pend) && k < 200) begin
         step();
         k++;
      end
      chk("quiesce", 64'(m_busy || c_pend || d_pend), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] v;
      reset = 1; dbg_lock = 0; p_new = 0; rand_lock = 0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; mem_rdata = '0;
      c_we = 0; c_addr = '0; c_wdata = '0; d_we = 0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         v = $urandom; env_mem[i] = v; mdl_mem[i] = v;
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_en", mem_en, 0);       chk("rst_mem_we", mem_we, 0);
      chk("rst_cpu_ack", cpu_ack, 0);     chk("rst_dbg_ack", dbg_ack, 0);
      chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_dbg_rdata", dbg_rdata, 0);
      @(negedge clk) reset = 0;

      // Both ports request continuously from reset: CPU wins the first tie, then alternate.
      p_new = 100;
      n = 0;
      while (ack_log.size() < 4 && n < 100) begin step(); n++; end
      chk("rr_count", 64'(ack_log.size() >= 4), 64'd1);
      if (ack_log.size() >= 4) begin
         chk("rr_first_ack_cyc", ack_cyc_log[0], 1 + LAT + 2);
         for (int i = 0; i < 4; i++) chk("rr_order", ack_log[i], i % 2);
         for (int i = 0; i < 3; i++) chk("rr_gap", ack_cyc_log[i+1] - ack_cyc_log[i], LAT + 3);
      end
      quiesce();

      // Directed CPU read; address changes one cycle after the grant.
      env_mem[8'h40] = 32'hDEAD_BEEF; mdl_mem[8'h40] = 32'hDEAD_BEEF;
      c_pend = 1; c_we = 0; c_addr = 32'h40; c_wdata = '0;
      en_cyc = -1; cack_cyc = -1; t0 = cyc + 1;
      step();
      c_addr = 32'h80;
      n = 0;
      while (c_pend && n < 20) begin step(); n++; end
      chk("rd_en_cyc", en_cyc - t0, 1);
      chk("rd_mem_addr", en_addr, 32'h40);
      chk("rd_ack_cyc", cack_cyc - t0, LAT + 2);
      chk("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);

      // Directed debug write.
      saved = m_drd;
      d_pend = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h1234_5678;
      en_cyc = -1; dack_cyc = -1; t0 = cyc + 1;
      n = 0;
      while (d_pend && n < 20) begin step(); n++; end
      chk("wr_en_cyc", en_cyc - t0, 1);
      chk("wr_mem_we", en_we, 1);
      chk("wr_mem_addr", en_addr, 32'h10);
      chk("wr_mem_wdata", en_wdata, 32'h1234_5678);
      chk("wr_ack_cyc", dack_cyc - t0, LAT + 2);
      chk("wr_dbg_rdata_kept", dbg_rdata, saved);
      quiesce();

      // Lock: only the debug port is served and the CPU stays stalled.
      dbg_lock = 1; p_new = 100; ack_log.delete(); ack_cyc_log.delete();
      stall_low = 0; ncpu = 0; ndbg = 0; n = 0;
      while (ndbg < 4 && n < 200) begin
         step();
         if (!cpu_stall) stall_low++;
         ncpu = 0; ndbg = 0;
         foreach (ack_log[i]) if (ack_log[i]) ndbg++; else ncpu++;
         n++;
      end
      chk("lock_dbg_count", ndbg, 4);
      chk("lock_cpu_count", ncpu, 0);
      chk("lock_stall_low", stall_low, 0);
      dbg_lock = 0; ack_log.delete(); n = 0;
      while (ack_log.size() < 1 && n < 50) begin step(); n++; end
      chk("unlock_seen", 64'(ack_log.size() >= 1), 64'd1);
      if (ack_log.size() >= 1) chk("unlock_cpu_first", ack_log[0], 0);
      quiesce();

      // Randomized traffic with lock toggling.
      p_new = 30; rand_lock = 1;
      repeat (1500) step();
      quiesce();

      // Reset in the middle of a WAIT cycle.
      c_pend = 1; c_we = 0; c_addr = $urandom; n = 0;
      while (!(m_busy && m_age == 3) && n < 20) begin step(); n++; end
      chk("mid_wait_reached", 64'(m_busy && m_age == 3), 64'd1);
      #1 reset = 1;
      #1;
      chk("mrst_mem_en", mem_en, 0);       chk("mrst_mem_we", mem_we, 0);
      chk("mrst_cpu_ack", cpu_ack, 0);     chk("mrst_dbg_ack", dbg_ack, 0);
      chk("mrst_mem_addr", mem_addr, 0);   chk("mrst_mem_wdata", mem_wdata, 0);
      chk("mrst_cpu_rdata", cpu_rdata, 0); chk("mrst_dbg_rdata", dbg_rdata, 0);
      model_reset();
      cpu_req = 0; dbg_req = 0;
      @(negedge clk);
      @(negedge clk) reset = 0;
      ack_log.delete();
      repeat (8) step();
      chk("post_rst_no_ack", ack_log.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
